// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_pkg
//  Purpose  : Shared types and constants for the data-memory bus controller.
//             Holds the access-sequencer state encoding, the default
//             memory-mapped serial register addresses, the default minimum
//             serial write-settle time, and the Ram1 address helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mem_bus_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SRD   = 4'd1,
    SWR   = 4'd2,
    SWE   = 4'd3,
    URD1  = 4'd4,
    URD2  = 4'd5,
    UWR1  = 4'd6,
    UWR2  = 4'd7,
    UWAIT = 4'd8,
    ACK   = 4'd9
  } state_t;

  localparam logic [15:0] UART_DATA_DEFAULT   = 16'hBF00;
  localparam logic [15:0] UART_STAT_DEFAULT   = 16'hBF01;
  localparam int unsigned WR_MIN_WAIT_DEFAULT = 3;

  // Ram1 is 256K words; the pipeline only reaches the low 64K.
  function automatic logic [17:0] to_ram_addr(input logic [15:0] word_addr);
    return {2'b00, word_addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_sync
//  Purpose  : 3-bit, two-flop synchronizer for the asynchronous serial
//             status lines, with synchronous active-low clear.
//  Ports    : clk       in   system clock
//             rst       in   synchronous active-low clear
//             async_in  in   [2:0] asynchronous inputs
//             sync_out  out  [2:0] inputs re-timed to clk (2-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] async_in,
  output logic [2:0] sync_out
);

  logic [2:0] r_meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta   <= '0;
      sync_out <= '0;
    end else begin
      r_meta   <= async_in;
      sync_out <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_ctrl
//  Purpose  : MEM-stage data-memory controller. Sequences multi-cycle
//             accesses on the ThinPad Ram1 bus, decodes the memory-mapped
//             serial port sharing that bus, returns load data and stalls
//             the pipeline until each access completes.
//  Config   : MEM_BUS_UART_EN - when defined, 16'hBF00/16'hBF01 decode to
//             the serial data/status registers; when undefined every
//             address goes to SRAM and the serial strobes stay high.
//  Ports    : clk, rst (sync active-low)
//             mem_read, mem_write, address[15:0], wdata[15:0]  MEM request
//             rdata[15:0]     load data, valid in ACK
//             mem_stall       pipeline freeze
//             ram_addr[17:0], ram_data[15:0] (inout), ram_en_n, ram_oe_n,
//             ram_we_n        Ram1 bus
//             uart_rdn, uart_wrn                     serial strobes
//             uart_data_ready, uart_tbre, uart_tsre  serial status (async)
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter logic [15:0] UART_DATA   = UART_DATA_DEFAULT,
  parameter logic [15:0] UART_STAT   = UART_STAT_DEFAULT,
  parameter int unsigned WR_MIN_WAIT = WR_MIN_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        mem_stall,
  output logic [17:0] ram_addr,
  inout  wire  [15:0] ram_data,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  state_t      r_state;
  logic        r_drive;
  logic [15:0] r_dout;

  logic        w_req;
  logic        w_sel_data;
  logic        w_sel_stat;
  logic [15:0] w_status;

  assign w_req     = mem_read | mem_write;
  assign mem_stall = w_req & (r_state != ACK);
  assign ram_data  = r_drive ? r_dout : 16'hzzzz;

`ifdef MEM_BUS_UART_EN
  localparam int unsigned WAIT_LAST = (WR_MIN_WAIT > 0) ? WR_MIN_WAIT - 1 : 0;
  localparam int          CNT_W     = (WAIT_LAST > 0) ? $clog2(WAIT_LAST + 1) : 1;

  logic [2:0]       r_sync;     // {data_ready, tbre, tsre}
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_tx_idle;

  mem_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in ({uart_data_ready, uart_tbre, uart_tsre}),
    .sync_out (r_sync)
  );

  assign w_tx_idle  = r_sync[1] & r_sync[0];
  assign w_sel_data = (address == UART_DATA);
  assign w_sel_stat = (address == UART_STAT);
  assign w_status   = {14'b0, r_sync[2], w_tx_idle};
`else
  logic w_unused;

  assign w_sel_data = 1'b0;
  assign w_sel_stat = 1'b0;
  assign w_status   = '0;
  assign uart_rdn   = 1'b1;
  assign uart_wrn   = 1'b1;
  assign w_unused   = ^{uart_data_ready, uart_tbre, uart_tsre,
                        UART_DATA, UART_STAT, WR_MIN_WAIT};
`endif

  // Sequencer with registered strobes: each strobe is set on the edge that
  // enters the state it belongs to, so the bus sees clean, glitch-free
  // levels for whole cycles. Reset drops every strobe at the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      rdata    <= '0;
      ram_addr <= '0;
      ram_en_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
      r_drive  <= 1'b0;
      r_dout   <= '0;
`ifdef MEM_BUS_UART_EN
      uart_rdn   <= 1'b1;
      uart_wrn   <= 1'b1;
      r_wait_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            ram_addr <= to_ram_addr(address);
            if (w_sel_data) begin
`ifdef MEM_BUS_UART_EN
              if (mem_write) begin
                uart_wrn <= 1'b0;
                r_drive  <= 1'b1;
                r_dout   <= wdata;
                r_state  <= UWR1;
              end else begin
                uart_rdn <= 1'b0;
                r_state  <= URD1;
              end
`endif
            end else if (w_sel_stat) begin
              // Status register is read-only; a store to it just completes.
              if (!mem_write) rdata <= w_status;
              r_state <= ACK;
            end else if (mem_write) begin
              ram_en_n <= 1'b0;
              ram_we_n <= 1'b0;
              r_drive  <= 1'b1;
              r_dout   <= wdata;
              r_state  <= SWR;
            end else begin
              ram_en_n <= 1'b0;
              ram_oe_n <= 1'b0;
              r_state  <= SRD;
            end
          end
        end

        SRD: begin
          rdata    <= ram_data;
          ram_en_n <= 1'b1;
          ram_oe_n <= 1'b1;
          r_state  <= ACK;
        end

        // Release we_n one cycle before the bus so data holds past the edge.
        SWR: begin
          ram_we_n <= 1'b1;
          r_state  <= SWE;
        end

        SWE: begin
          ram_en_n <= 1'b1;
          r_drive  <= 1'b0;
          r_state  <= ACK;
        end

`ifdef MEM_BUS_UART_EN
        URD1: r_state <= URD2;

        URD2: begin
          rdata    <= {8'b0, ram_data[7:0]};
          uart_rdn <= 1'b1;
          r_state  <= ACK;
        end

        UWR1: begin
          uart_wrn <= 1'b1;
          r_state  <= UWR2;
        end

        UWR2: begin
          r_drive    <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= UWAIT;
        end

        // The UART needs a few cycles before tbre/tsre reflect the new
        // byte, so idle flags are ignored until the minimum wait elapses.
        UWAIT: begin
          if (r_wait_cnt == CNT_W'(WAIT_LAST)) begin
            if (w_tx_idle) r_state <= ACK;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
`endif

        ACK: r_state <= IDLE;

        default: begin
          ram_en_n <= 1'b1;
          ram_oe_n <= 1'b1;
          ram_we_n <= 1'b1;
          r_drive  <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
